// File: rtl/sram_rd_arbiter_if.sv
// Requester-side bus of the SRAM read arbiter: per-requester req/lock/addr in,
// one-hot grant and returned-data strobe out, shared read data.
interface sram_rd_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
);
  // Handshake: a requester raises req[i] with addr[i] (and lock[i]) and holds
  // them until gnt[i] is seen high in the same cycle; the edge that closes a
  // cycle with gnt[i]=1 accepts the read, and rvalid[i] with rdata follows on
  // the next cycle. There is no backpressure on the return path.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  modport master (output req, output lock, output addr,
                  input gnt, input rvalid, input rdata);
  modport slave  (input req, input lock, input addr,
                  output gnt, output rvalid, output rdata);
endinterface

// File: rtl/sram_rd_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one 1-cycle-latency SRAM
// read port between NUM_REQ requesters; read data is routed back by owner.
module sram_rd_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 16,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = $clog2(MAX_LOCK + 1)
) (
  input  logic                  clk,
  input  logic                  reset_b,
  sram_rd_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0]     sram_rd_address,
  input  logic [DATA_W-1:0]     sram_rd_data,
  output logic                  arb_busy,
  output logic [PTR_W-1:0]      dbg_rr_ptr,
  output logic [CNT_W-1:0]      dbg_lock_cnt
);

  localparam logic [PTR_W-1:0] LAST    = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   lock_owner;
  logic               lock_vld;
  logic [CNT_W-1:0]   lock_cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [NUM_REQ-1:0] rvalid_q;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic               lock_hit;
  logic               any_gnt;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   scan;
  logic [NUM_REQ-1:0] gnt_c;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = bus.addr[i*ADDR_W +: ADDR_W];
    end
  end

  // A locked owner keeps priority until it has taken MAX_LOCK grants in a row;
  // after that it competes in the normal rotation starting at rr_ptr.
  always_comb begin
    lock_hit = lock_vld && bus.req[lock_owner] && (lock_cnt < MAX_CNT);
    any_gnt  = 1'b0;
    sel      = '0;
    scan     = rr_ptr;
    if (lock_hit) begin
      any_gnt = 1'b1;
      sel     = lock_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!any_gnt && bus.req[scan]) begin
          any_gnt = 1'b1;
          sel     = scan;
        end
        scan = (scan == LAST) ? '0 : scan + 1'b1;
      end
    end
  end

  always_comb begin
    gnt_c = '0;
    if (any_gnt) gnt_c[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rr_ptr     <= '0;
      lock_owner <= '0;
      lock_vld   <= 1'b0;
      lock_cnt   <= '0;
      addr_q     <= '0;
      rvalid_q   <= '0;
    end else begin
      rvalid_q <= gnt_c;
      if (any_gnt) begin
        rr_ptr <= (sel == LAST) ? '0 : sel + 1'b1;
        addr_q <= addr_arr[sel];
        if (bus.lock[sel]) begin
          lock_vld   <= 1'b1;
          lock_owner <= sel;
          // An exhausted owner that wins again through rotation opens a new burst.
          lock_cnt   <= (lock_vld && (lock_owner == sel) && (lock_cnt < MAX_CNT))
                        ? lock_cnt + 1'b1 : CNT_W'(1);
        end else begin
          lock_vld <= 1'b0;
          lock_cnt <= '0;
        end
      end else begin
        // No grant means no requests at all, so any lock owner has dropped req.
        lock_vld <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end

  assign bus.gnt         = gnt_c;
  assign bus.rvalid      = rvalid_q;
  assign bus.rdata       = sram_rd_data;
  assign sram_rd_address = any_gnt ? addr_arr[sel] : addr_q;
  assign arb_busy        = (|bus.req) | (|rvalid_q);
  assign dbg_rr_ptr      = rr_ptr;
  assign dbg_lock_cnt    = lock_cnt;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed bench: a 2-requester arbiter (MAX_LOCK=4) and a 3-requester arbiter
// each read a shared SRAM model; expected grants and data are hand-derived.
module tb_sram_rd_arbiter;

  logic clk;
  logic reset_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit inv_en   = 1'b0;

  logic [15:0] mem [4096];

  sram_rd_arbiter_if #(.NUM_REQ(2), .ADDR_W(12), .DATA_W(16)) b2 ();
  sram_rd_arbiter_if #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(16)) b3 ();

  logic [11:0] sram_addr2, sram_addr3;
  logic [15:0] sram_data2, sram_data3;
  logic        busy2, busy3;
  logic [0:0]  rr2;
  logic [1:0]  rr3;
  logic [2:0]  lcnt2;
  logic [4:0]  lcnt3;

  sram_rd_arbiter #(.NUM_REQ(2), .ADDR_W(12), .DATA_W(16), .MAX_LOCK(4)) dut2 (
    .clk(clk), .reset_b(reset_b), .bus(b2),
    .sram_rd_address(sram_addr2), .sram_rd_data(sram_data2),
    .arb_busy(busy2), .dbg_rr_ptr(rr2), .dbg_lock_cnt(lcnt2)
  );

  sram_rd_arbiter #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(16), .MAX_LOCK(16)) dut3 (
    .clk(clk), .reset_b(reset_b), .bus(b3),
    .sram_rd_address(sram_addr3), .sram_rd_data(sram_data3),
    .arb_busy(busy3), .dbg_rr_ptr(rr3), .dbg_lock_cnt(lcnt3)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  // synchronous-read SRAM models
  always_ff @(posedge clk) sram_data2 <= mem[sram_addr2];
  always_ff @(posedge clk) sram_data3 <= mem[sram_addr3];

  function automatic logic [15:0] mem_val(input logic [11:0] a);
    return (a == 12'h005) ? 16'hBEEF : (16'(a) ^ 16'hA5A5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one-hot-or-zero invariant on grants and read strobes
  always @(negedge clk) begin
    if (inv_en) begin
      chk("inv_gnt2",    32'($onehot0(b2.gnt)),    32'd1);
      chk("inv_rvalid2", 32'($onehot0(b2.rvalid)), 32'd1);
      chk("inv_gnt3",    32'($onehot0(b3.gnt)),    32'd1);
      chk("inv_rvalid3", 32'($onehot0(b3.rvalid)), 32'd1);
    end
  end

  // driver task: inputs already applied; check at the falling edge, then
  // advance to just after the next rising edge
  task automatic step(input bit d3, input string tag, input logic [2:0] eg,
                      input logic [11:0] ea, input logic [2:0] erv,
                      input logic [15:0] erd, input logic eb);
    logic [2:0]  g, rv;
    logic [11:0] a;
    logic [15:0] d;
    logic        b;
    @(negedge clk);
    g  = d3 ? b3.gnt    : {1'b0, b2.gnt};
    rv = d3 ? b3.rvalid : {1'b0, b2.rvalid};
    a  = d3 ? sram_addr3 : sram_addr2;
    d  = d3 ? b3.rdata  : b2.rdata;
    b  = d3 ? busy3     : busy2;
    chk({tag, "/gnt"},    32'(g),  32'(eg));
    chk({tag, "/addr"},   32'(a),  32'(ea));
    chk({tag, "/rvalid"}, 32'(rv), 32'(erv));
    chk({tag, "/busy"},   32'(b),  32'(eb));
    if (erv != 3'b000) chk({tag, "/rdata"}, 32'(d), 32'(erd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  lk_g [10];
    logic [1:0]  prev;
    logic [11:0] pa;

    for (int i = 0; i < 4096; i++) mem[i] = mem_val(12'(i));
    lk_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    reset_b = 1'b0;
    b2.req = '0; b2.lock = '0; b2.addr = '0;
    b3.req = '0; b3.lock = '0; b3.addr = '0;
    #12;
    chk("rst/gnt2",    32'(b2.gnt),    32'd0);
    chk("rst/rvalid2", 32'(b2.rvalid), 32'd0);
    chk("rst/addr2",   32'(sram_addr2), 32'd0);
    chk("rst/busy2",   32'(busy2),     32'd0);
    chk("rst/rr2",     32'(rr2),       32'd0);
    chk("rst/rvalid3", 32'(b3.rvalid), 32'd0);
    chk("rst/addr3",   32'(sram_addr3), 32'd0);
    chk("rst/busy3",   32'(busy3),     32'd0);
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    inv_en  = 1'b1;

    // single read from requester 0
    b2.req = 2'b01; b2.addr = {12'h000, 12'h005};
    step(1'b0, "single_gnt",  3'b001, 12'h005, 3'b000, 16'h0, 1'b1);
    b2.req = 2'b00;
    step(1'b0, "single_data", 3'b000, 12'h005, 3'b001, 16'hBEEF, 1'b1);
    step(1'b0, "single_idle", 3'b000, 12'h005, 3'b000, 16'h0, 1'b0);

    // idle after grant: address holds the last granted value
    b2.req = 2'b10; b2.addr = {12'h07F, 12'h000};
    step(1'b0, "idle_gnt",  3'b010, 12'h07F, 3'b000, 16'h0, 1'b1);
    b2.req = 2'b00;
    step(1'b0, "idle_data", 3'b000, 12'h07F, 3'b010, mem_val(12'h07F), 1'b1);
    step(1'b0, "idle_hold", 3'b000, 12'h07F, 3'b000, 16'h0, 1'b0);

    // alternating round robin, no lock
    b2.req = 2'b11; b2.addr = {12'h020, 12'h010};
    for (int c = 0; c < 4; c++) begin
      step(1'b0, $sformatf("rr_c%0d", c),
           (c % 2 == 0) ? 3'b001 : 3'b010,
           (c % 2 == 0) ? 12'h010 : 12'h020,
           (c == 0) ? 3'b000 : ((c % 2 == 0) ? 3'b010 : 3'b001),
           (c % 2 == 0) ? mem_val(12'h020) : mem_val(12'h010), 1'b1);
    end
    b2.req = 2'b00;
    step(1'b0, "rr_tail", 3'b000, 12'h020, 3'b010, mem_val(12'h020), 1'b1);

    // bounded burst lock on requester 0
    b2.req = 2'b11; b2.lock = 2'b01; b2.addr = {12'h040, 12'h030};
    for (int c = 0; c < 10; c++) begin
      if (c == 4) chk("lock_cnt_max", 32'(lcnt2), 32'd4);
      prev = (c == 0) ? 2'b00 : lk_g[c-1];
      pa   = (prev == 2'b10) ? 12'h040 : 12'h030;
      step(1'b0, $sformatf("lock_c%0d", c), {1'b0, lk_g[c]},
           (lk_g[c] == 2'b01) ? 12'h030 : 12'h040,
           {1'b0, prev}, mem_val(pa), 1'b1);
    end
    b2.req = 2'b00; b2.lock = 2'b00;
    step(1'b0, "lock_tail", 3'b000, 12'h040, 3'b010, mem_val(12'h040), 1'b1);

    // reset while a read is in flight
    b2.req = 2'b10; b2.addr = {12'h060, 12'h050};
    step(1'b0, "rst_gnt", 3'b010, 12'h060, 3'b000, 16'h0, 1'b1);
    chk("rst_inflight/rvalid", 32'(b2.rvalid), 32'(2'b10));
    reset_b = 1'b0;
    #1;
    chk("rst_async/rvalid", 32'(b2.rvalid), 32'd0);
    chk("rst_async/rr",     32'(rr2),       32'd0);
    b2.req = 2'b11;
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    step(1'b0, "post_rst_c0", 3'b001, 12'h050, 3'b000, 16'h0, 1'b1);
    step(1'b0, "post_rst_c1", 3'b010, 12'h060, 3'b001, mem_val(12'h050), 1'b1);
    b2.req = 2'b00;
    step(1'b0, "post_rst_c2", 3'b000, 12'h060, 3'b010, mem_val(12'h060), 1'b1);

    // three requesters, plain rotation
    b3.req = 3'b111; b3.addr = {12'h300, 12'h200, 12'h100};
    step(1'b1, "n3_c0", 3'b001, 12'h100, 3'b000, 16'h0, 1'b1);
    step(1'b1, "n3_c1", 3'b010, 12'h200, 3'b001, mem_val(12'h100), 1'b1);
    step(1'b1, "n3_c2", 3'b100, 12'h300, 3'b010, mem_val(12'h200), 1'b1);
    step(1'b1, "n3_c3", 3'b001, 12'h100, 3'b100, mem_val(12'h300), 1'b1);
    b3.req = 3'b000;
    step(1'b1, "n3_tail", 3'b000, 12'h100, 3'b001, mem_val(12'h100), 1'b1);
    step(1'b1, "n3_idle", 3'b000, 12'h100, 3'b000, 16'h0, 1'b0);

    inv_en = 1'b0;
    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
